// File: rtl/sevenseg_frame_decoder.sv
// sevenseg_frame_decoder
// Watches a multiplexed, active-low seven-segment bus and decodes each digit
// back to a hex value or a symbol. Each digit has a debounce filter. Once every
// digit of a frame has been accepted, the packed frame is offered on a
// valid/ready output.
//
// Optional build macro: SEVENSEG_FRAME_DECODER_ERRCNT_EN
//   When defined, the block adds an 8-bit saturating err_cnt output. It counts
//   accepted digits that decode as invalid patterns. It also adds an err_clr
//   input that clears the counter.
//
// Per-digit field in frame_data: {dp, kind[1:0], val[3:0]}
//   kind 00 = hex, 01 = blank, 10 = minus, 11 = invalid (val = raw seg[3:0])

module sevenseg_frame_decoder #(
  parameter int NUM_DIGITS = 4,
  parameter int IDX_W      = 2,
  parameter int STABLE_CNT = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              seg,
  input  logic [IDX_W-1:0]        seg_idx,
  input  logic                    seg_stb,
  output logic [7*NUM_DIGITS-1:0] frame_data,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    frame_ovf,
  output logic                    bad_idx
`ifdef SEVENSEG_FRAME_DECODER_ERRCNT_EN
  ,
  output logic [7:0]              err_cnt,
  input  logic                    err_clr
`endif
);

  localparam int              FW           = 7 * NUM_DIGITS;
  localparam logic [3:0]      STABLE       = 4'(STABLE_CNT);
  localparam logic [IDX_W:0]  NUM_DIGITS_W = (IDX_W + 1)'(NUM_DIGITS);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t            state_reg, state_next;
  logic [FW-1:0]     frame_data_reg;
  logic              frame_valid_reg;
  logic              frame_ovf_reg;
  logic              bad_idx_reg;
  logic [FW-1:0]     shadow_reg, shadow_next;
  logic [NUM_DIGITS-1:0] seen_reg, seen_next;
  logic [NUM_DIGITS-1:0] accept;

  logic              idx_ok;
  logic              dec_dp;
  logic [1:0]        dec_kind;
  logic [3:0]        dec_val;
  logic [6:0]        dec_word;

  logic              all_seen;
  logic              handshake;
  logic              load_frame;
  logic              drop_valid;
  logic              set_ovf;

  assign idx_ok = ({1'b0, seg_idx} < NUM_DIGITS_W);

  // Decode the current bus pattern. Only the digit being strobed consumes it.
  always_comb begin
    dec_dp   = ~seg[7];
    dec_kind = 2'b00;
    dec_val  = 4'h0;
    case (seg[6:0])
      7'h40:         dec_val = 4'h0;
      7'h79:         dec_val = 4'h1;
      7'h24:         dec_val = 4'h2;
      7'h30:         dec_val = 4'h3;
      7'h19:         dec_val = 4'h4;
      7'h12:         dec_val = 4'h5;
      7'h02:         dec_val = 4'h6;
      7'h78:         dec_val = 4'h7;
      7'h00:         dec_val = 4'h8;
      7'h10, 7'h18:  dec_val = 4'h9;
      7'h08:         dec_val = 4'hA;
      7'h03:         dec_val = 4'hB;
      7'h46:         dec_val = 4'hC;
      7'h21:         dec_val = 4'hD;
      7'h06:         dec_val = 4'hE;
      7'h0E:         dec_val = 4'hF;
      7'h7F:         dec_kind = 2'b01;
      7'h3F:         dec_kind = 2'b10;
      default: begin
        dec_kind = 2'b11;
        dec_val  = seg[3:0];
      end
    endcase
  end

  assign dec_word = {dec_dp, dec_kind, dec_val};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      localparam logic [IDX_W-1:0] GI_IDX = IDX_W'(gi);

      logic [7:0] hist_reg;
      logic [3:0] cnt_reg, cnt_next;
      logic       hit;
      logic       same;

      assign hit  = seg_stb & idx_ok & (seg_idx == GI_IDX);
      assign same = (seg == hist_reg);

      // Run-length count of identical strobes. It saturates at the acceptance threshold.
      always_comb begin
        cnt_next = cnt_reg;
        if (hit) begin
          if (!same)
            cnt_next = 4'd1;
          else if (cnt_reg >= STABLE)
            cnt_next = STABLE;
          else
            cnt_next = cnt_reg + 4'd1;
        end
      end

      // An identical strobe after saturation accepts again. This refreshes seen and the shadow value.
      assign accept[gi]             = hit & (cnt_next == STABLE);
      assign seen_next[gi]          = hit ? accept[gi] : seen_reg[gi];
      assign shadow_next[7*gi +: 7] = accept[gi] ? dec_word : shadow_reg[7*gi +: 7];

      // Per-digit history and counter. Only a strobe addressed to this digit updates them.
      always_ff @(posedge clk) begin
        if (reset) begin
          hist_reg <= 8'h00;
          cnt_reg  <= 4'd0;
        end else if (hit) begin
          hist_reg <= seg;
          cnt_reg  <= cnt_next;
        end
      end
    end
  endgenerate

  assign all_seen  = &seen_next;
  assign handshake = frame_valid_reg & frame_ready;

  // Frame state register.
  always_ff @(posedge clk) begin
    if (reset)
      state_reg <= COLLECT;
    else
      state_reg <= state_next;
  end

  // Frame sequencing. A completion in the handshake cycle reloads without an idle gap.
  always_comb begin
    state_next = state_reg;
    load_frame = 1'b0;
    drop_valid = 1'b0;
    set_ovf    = 1'b0;
    case (state_reg)
      COLLECT: begin
        if (all_seen) begin
          load_frame = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (handshake) begin
          if (all_seen) begin
            load_frame = 1'b1;
          end else begin
            drop_valid = 1'b1;
            state_next = COLLECT;
          end
        end else if (all_seen) begin
          set_ovf = 1'b1;
        end
      end
      default: state_next = COLLECT;
    endcase
  end

  // Shadow, seen flags, output frame and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_reg      <= '0;
      seen_reg        <= '0;
      frame_data_reg  <= '0;
      frame_valid_reg <= 1'b0;
      frame_ovf_reg   <= 1'b0;
      bad_idx_reg     <= 1'b0;
    end else begin
      shadow_reg  <= shadow_next;
      seen_reg    <= load_frame ? '0 : seen_next;
      bad_idx_reg <= seg_stb & ~idx_ok;
      if (load_frame) begin
        frame_data_reg  <= shadow_next;
        frame_valid_reg <= 1'b1;
      end else if (drop_valid) begin
        frame_valid_reg <= 1'b0;
      end
      if (set_ovf)
        frame_ovf_reg <= 1'b1;
    end
  end

  assign frame_data  = frame_data_reg;
  assign frame_valid = frame_valid_reg;
  assign frame_ovf   = frame_ovf_reg;
  assign bad_idx     = bad_idx_reg;

`ifdef SEVENSEG_FRAME_DECODER_ERRCNT_EN
  logic [7:0] err_cnt_reg;
  logic       err_hit;

  assign err_hit = (|accept) & (dec_kind == 2'b11);

  // Saturating count of accepted invalid digits. A clear wins over an increment.
  always_ff @(posedge clk) begin
    if (reset)
      err_cnt_reg <= 8'h00;
    else if (err_clr)
      err_cnt_reg <= 8'h00;
    else if (err_hit && (err_cnt_reg != 8'hFF))
      err_cnt_reg <= err_cnt_reg + 8'h01;
  end

  assign err_cnt = err_cnt_reg;
`endif

endmodule

// File: tb/tb_sevenseg_frame_decoder.sv
// Testbench for sevenseg_frame_decoder.
// The driver feeds directed and random strobes into a reference model. The
// model pushes each expected frame into a queue. A monitor pops that queue on
// every output handshake and checks the status outputs on every cycle.
`timescale 1ns/1ps

module tb_sevenseg_frame_decoder;

  localparam int ND = 4;
  localparam int IW = 3;
  localparam int SC = 2;
  localparam int FW = 7 * ND;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    seg = 8'h00;
  logic [IW-1:0] seg_idx = '0;
  logic          seg_stb = 1'b0;
  logic [FW-1:0] frame_data;
  logic          frame_valid;
  logic          frame_ready = 1'b0;
  logic          frame_ovf;
  logic          bad_idx;

  always #5 clk = ~clk;

  sevenseg_frame_decoder #(
    .NUM_DIGITS (ND),
    .IDX_W      (IW),
    .STABLE_CNT (SC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .seg         (seg),
    .seg_idx     (seg_idx),
    .seg_stb     (seg_stb),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_ovf   (frame_ovf),
    .bad_idx     (bad_idx)
  );

  int checks = 0;
  int errors = 0;

  logic [FW-1:0] exp_q[$];

  // Reference model state: last pattern, run length, accepted flag and value per digit.
  logic [7:0] m_hist [ND];
  int         m_run  [ND];
  bit         m_seen [ND];
  logic [6:0] m_val  [ND];
  bit         m_busy;
  bit         m_ovf;
  bit         m_bad;
  bit         running = 1'b0;

  logic [6:0] hex_pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [7:0] pool [4] = '{8'hC0, 8'hF9, 8'h7F, 8'h55};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] ref_decode(input logic [7:0] s);
    logic dp;
    dp = ~s[7];
    for (int v = 0; v < 16; v++)
      if (s[6:0] == hex_pat[v]) return {dp, 2'b00, 4'(v)};
    if (s[6:0] == 7'h18) return {dp, 2'b00, 4'h9};
    if (s[6:0] == 7'h7F) return {dp, 2'b01, 4'h0};
    if (s[6:0] == 7'h3F) return {dp, 2'b10, 4'h0};
    return {dp, 2'b11, s[3:0]};
  endfunction

  task automatic model_step(input bit rst, input bit stb, input logic [7:0] s,
                            input int idx, input bit rdy);
    bit all;
    logic [FW-1:0] frame;
    if (rst) begin
      for (int d = 0; d < ND; d++) begin
        m_hist[d] = 8'h00; m_run[d] = 0; m_seen[d] = 0; m_val[d] = 7'h00;
      end
      m_busy = 0; m_ovf = 0; m_bad = 0;
      exp_q.delete();
      return;
    end
    m_bad = stb && (idx >= ND);
    if (stb && idx < ND) begin
      if (s == m_hist[idx]) begin
        m_run[idx] = (m_run[idx] < SC) ? m_run[idx] + 1 : SC;
      end else begin
        m_hist[idx] = s;
        m_run[idx]  = 1;
      end
      if (m_run[idx] == SC) begin
        m_val[idx]  = ref_decode(s);
        m_seen[idx] = 1;
      end else begin
        m_seen[idx] = 0;
      end
    end
    all = 1;
    for (int d = 0; d < ND; d++) all &= m_seen[d];
    if (all && (!m_busy || rdy)) begin
      frame = '0;
      for (int d = 0; d < ND; d++) frame[7*d +: 7] = m_val[d];
      exp_q.push_back(frame);
      for (int d = 0; d < ND; d++) m_seen[d] = 0;
      m_busy = 1;
    end else if (m_busy && rdy) begin
      m_busy = 0;
    end else if (all) begin
      m_ovf = 1;
    end
  endtask

  task automatic cyc(input bit rst, input bit stb, input logic [7:0] s,
                     input int idx, input bit rdy);
    @(negedge clk);
    reset       = rst;
    seg_stb     = stb;
    seg         = s;
    seg_idx     = IW'(idx);
    frame_ready = rdy;
    @(posedge clk);
    #1;
    model_step(rst, stb, s, idx, rdy);
    if (rst) chk("reset_data", frame_data, '0);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int k = 0; k < n; k++) cyc(0, 0, 8'h00, 0, rdy);
  endtask

  task automatic frame4(input logic [7:0] p0, input logic [7:0] p1,
                        input logic [7:0] p2, input logic [7:0] p3, input bit rdy);
    logic [7:0] p [4];
    p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
    for (int d = 0; d < 4; d++)
      for (int r = 0; r < 2; r++) cyc(0, 1, p[d], d, rdy);
  endtask

  // Monitor: compare status each cycle and pop an expected frame on every handshake.
  initial begin
    logic [FW-1:0] exp;
    forever begin
      @(negedge clk);
      #2;
      if (running && !reset) begin
        chk("frame_valid", frame_valid, m_busy);
        chk("frame_ovf", frame_ovf, m_ovf);
        chk("bad_idx", bad_idx, m_bad);
        if (frame_valid === 1'b1 && frame_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame actual=%0h required=none", frame_data);
          end else begin
            exp = exp_q.pop_front();
            chk("frame_data", frame_data, exp);
            $display("frame accepted data=%0h", frame_data);
          end
        end
      end
    end
  end

  initial begin
    int idx;
    logic [7:0] s;
    bit rst, stb, rdy;

    cyc(1, 0, 8'h00, 0, 0);
    running = 1'b1;

    // Basic hex frame with the consumer ready.
    frame4(8'hC0, 8'hF9, 8'hA4, 8'hB0, 1);
    idle(3, 1);

    // A changed pattern restarts the filter.
    cyc(0, 1, 8'h92, 1, 1);
    cyc(0, 1, 8'h82, 1, 1);
    cyc(0, 1, 8'h82, 1, 1);
    for (int d = 0; d < 4; d++)
      if (d != 1) begin
        cyc(0, 1, 8'h99, d, 1);
        cyc(0, 1, 8'h99, d, 1);
      end
    idle(3, 1);

    // Blank, minus and invalid patterns with both dp polarities.
    frame4(8'h7F, 8'h3F, 8'hBF, 8'h55, 1);
    idle(3, 1);

    // Overflow: a second frame completes while the first is held.
    frame4(8'hC0, 8'hF9, 8'hA4, 8'hB0, 0);
    idle(2, 0);
    frame4(8'h99, 8'h92, 8'h82, 8'hF8, 0);
    idle(2, 0);
    idle(4, 1);

    // Out-of-range digit index.
    cyc(0, 1, 8'hC0, 5, 1);
    idle(2, 1);

    // Reset mid-frame with three digits already accepted.
    for (int d = 0; d < 3; d++) begin
      cyc(0, 1, 8'h80, d, 1);
      cyc(0, 1, 8'h80, d, 1);
    end
    cyc(1, 0, 8'h00, 0, 1);
    for (int d = 1; d < 4; d++) begin
      cyc(0, 1, 8'h88, d, 1);
      cyc(0, 1, 8'h88, d, 1);
    end
    idle(2, 1);
    cyc(0, 1, 8'h83, 0, 1);
    cyc(0, 1, 8'h83, 0, 1);
    idle(3, 1);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 399) == 0);
      stb = ($urandom_range(0, 3) != 0);
      idx = ($urandom_range(0, 11) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
      s   = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 3)];
      rdy = ($urandom_range(0, 2) != 0);
      cyc(rst, stb, s, idx, rdy);
    end

    // Drain any held frames.
    idle(6, 1);
    running = 1'b0;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
